// File: rtl/sha2_digest_uart_tx.sv
// -----------------------------------------------------------------------------
// sha2_digest_uart_tx
//   Serialises one 256-bit SHA-256 digest per valid/ready handshake onto an
//   8N1 UART line, most significant byte first, LSB first within each char.
//
//   Optional build macro: HEX_ASCII_EN
//     undefined : 32 raw bytes per digest
//     defined   : 64 lowercase ASCII hex chars (high nibble first) + CR, LF
//
// Ports
//   clk           in   1    system clock, rising edge
//   rst_n         in   1    synchronous reset, active-low
//   digest_valid  in   1    digest present on digest
//   digest        in   256  hash result, [255:248] sent first
//   digest_ready  out  1    idle, will accept a digest
//   tx            out  1    UART serial out, idle high
//   busy          out  1    frame sequence in progress
//   done          out  1    one-cycle pulse when the last stop bit completes
// -----------------------------------------------------------------------------
// state  | meaning
// IDLE   | line high, waiting for a digest handshake
// START  | start bit (0) for CLKS_PER_BIT clocks
// DATA   | 8 data bits, LSB first, CLKS_PER_BIT clocks each
// STOP   | stop bit (1); then next char or back to IDLE
// -----------------------------------------------------------------------------
module sha2_digest_uart_tx #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD        = 115200
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         digest_valid,
  input  logic [255:0] digest,
  output logic         digest_ready,
  output logic         tx,
  output logic         busy,
  output logic         done
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("sha2_digest_uart_tx: CLKS_PER_BIT must be >= 2");
    end
  endgenerate

  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

`ifdef HEX_ASCII_EN
  localparam int NUM_CHARS = 66;
`else
  localparam int NUM_CHARS = 32;
`endif
  localparam int CHAR_W = (NUM_CHARS > 64) ? 7 : 6;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CHAR_W-1:0] CHAR_LAST = CHAR_W'(NUM_CHARS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [CHAR_W-1:0] char_q, char_d;
  logic [255:0]      shreg_q, shreg_d;
  logic              tx_q, tx_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic       accept;
  logic       baud_end;
  logic [7:0] cur_char;
  logic       shift_now;

  assign accept   = digest_valid & ready_q;
  assign baud_end = (baud_q == BAUD_LAST);

  // Character currently on the wire, always taken from the top of the shift register.
`ifdef HEX_ASCII_EN
  logic [3:0] nib;
  always_comb begin
    nib = char_q[0] ? shreg_q[251:248] : shreg_q[255:252];
    if (char_q == CHAR_W'(64))
      cur_char = 8'h0D;
    else if (char_q == CHAR_W'(65))
      cur_char = 8'h0A;
    else if (nib < 4'd10)
      cur_char = {4'h3, nib};
    else
      cur_char = 8'h57 + {4'h0, nib};  // 'a' - 10
  end
  // A byte is consumed after its low-nibble char.
  assign shift_now = char_q[0];
`else
  assign cur_char  = shreg_q[255:248];
  assign shift_now = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    char_d  = char_q;
    shreg_d = shreg_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (accept) begin
          state_d = S_START;
          bit_d   = '0;
          char_d  = '0;
          shreg_d = digest;
        end
      end
      S_START: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (shift_now)
            shreg_d = {shreg_q[247:0], 8'h00};
          if (char_q == CHAR_LAST) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            char_d  = char_q + CHAR_W'(1);
            state_d = S_START;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // tx follows the state one clock later, so the start bit appears on the edge
  // after acceptance; the line stays high after the final stop bit anyway.
  always_comb begin
    case (state_q)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = cur_char[bit_q];
      default: tx_d = 1'b1;
    endcase
  end

  assign ready_d = (state_d == S_IDLE);
  assign busy_d  = (state_d != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      char_q  <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      char_q  <= char_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign digest_ready = ready_q;
  assign tx           = tx_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_sha2_digest_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_sha2_digest_uart_tx
//   Directed bench for sha2_digest_uart_tx at CLKS_PER_BIT = 10. A UART
//   receiver model samples tx mid-bit; received chars are reassembled into a
//   digest and compared against the digest that was offered.
// -----------------------------------------------------------------------------
module tb_sha2_digest_uart_tx;

  localparam int CPB = 10;
`ifdef HEX_ASCII_EN
  localparam int NCH = 66;
`else
  localparam int NCH = 32;
`endif
  localparam int FRAME_CLKS = 10 * CPB;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         digest_valid = 1'b0;
  logic [255:0] digest = '0;
  logic         digest_ready;
  logic         tx;
  logic         busy;
  logic         done;

  sha2_digest_uart_tx #(
    .CLK_FREQ_HZ(1_000_000),
    .BAUD       (100_000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digest_valid(digest_valid),
    .digest      (digest),
    .digest_ready(digest_ready),
    .tx          (tx),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int done_seen = 0;
  always @(negedge clk) if (done === 1'b1) done_seen <= done_seen + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  logic [7:0] rxc [NCH];

  // Receiver model; call at a negedge. Waits for a start bit, samples mid-bit.
  task automatic rx_char(output logic [7:0] c, output bit bad);
    int w;
    bad = 1'b0;
    c   = '0;
    w   = 0;
    while (tx !== 1'b0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (w >= 500) begin
      bad = 1'b1;
      return;
    end
    repeat (CPB / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      c[i] = tx;
    end
    repeat (CPB) @(negedge clk);
    if (tx !== 1'b1) bad = 1'b1;
  endtask

  // Receive all chars of one digest and wait for done; lat = clocks from accept edge.
  task automatic rx_all(input int a, input bit swap, input logic [255:0] alt,
                        output int lat, output bit bad);
    bit t;
    int w;
    bad = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      rx_char(rxc[k], t);
      if (t) bad = 1'b1;
      if (swap && k == 3) digest = alt;
    end
    w = 0;
    while (done !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    lat = (done === 1'b1) ? cyc - a : -1;
  endtask

  task automatic xfer(input logic [255:0] d, input bit hold, input logic [255:0] alt,
                      output int lat, output bit bad);
    int w;
    int a;
    w = 0;
    while (digest_ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) begin
      bad = 1'b1;
      lat = -1;
      return;
    end
    digest       = d;
    digest_valid = 1'b1;
    @(negedge clk);
    a = cyc;
    if (!hold) digest_valid = 1'b0;
    digest = ~d;  // must not affect the digest already accepted
    rx_all(a, hold, alt, lat, bad);
  endtask

  function automatic logic [3:0] hexval(input logic [7:0] c);
    if (c >= 8'h61) return 4'(c - 8'h57);
    return 4'(c - 8'h30);
  endfunction

  function automatic logic [255:0] decode();
    logic [255:0] r;
    r = '0;
    for (int k = 0; k < 32; k++) begin
`ifdef HEX_ASCII_EN
      r[255 - 8*k -: 8] = {hexval(rxc[2*k]), hexval(rxc[2*k + 1])};
`else
      r[255 - 8*k -: 8] = rxc[k];
`endif
    end
    return r;
  endfunction

  typedef struct {
    logic [255:0] d;
    logic [7:0]   first;
    logic [7:0]   last;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int lat;
    bit bad;
    int a;
    int ds;
    logic [255:0] got;
    logic [255:0] d2;

    vecs[0] = '{d: {8'h01, 248'h0},           first: 8'h01, last: 8'h00};
    vecs[1] = '{d: {8'hA5, 240'h0, 8'h3C},    first: 8'hA5, last: 8'h3C};
    vecs[2] = '{d: {256{1'b1}},               first: 8'hFF, last: 8'hFF};
    vecs[3] = '{d: 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                first: 8'h00, last: 8'h1F};

    // reset held 3 clocks
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ready", digest_ready, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", digest_ready, 1);

`ifndef HEX_ASCII_EN
    // first-frame waveform for byte 0x01, valid pulsed for one clock
    begin
      logic [100:1] act_w;
      logic [100:1] exp_w;
      int w;
      for (int k = 1; k <= 100; k++)
        exp_w[k] = (k <= 10) ? 1'b0 : (k <= 20) ? 1'b1 : (k <= 90) ? 1'b0 : 1'b1;
      digest       = {8'h01, 248'h0};
      digest_valid = 1'b1;
      @(negedge clk);
      a = cyc;
      digest_valid = 1'b0;
      chk("ready_low_after_accept", digest_ready, 0);
      chk("busy_after_accept", busy, 1);
      chk("tx_high_on_accept_edge", tx, 1);
      for (int k = 1; k <= 100; k++) begin
        @(negedge clk);
        act_w[k] = tx;
      end
      chk("frame0_waveform", act_w, exp_w);
      w = 0;
      while (done !== 1'b1 && w < 4000) begin
        @(negedge clk);
        w++;
      end
      chk("frame01_latency", (done === 1'b1) ? cyc - a : -1, 3200);
    end
`endif

    // table-driven digests
    for (int v = 0; v < 4; v++) begin
      xfer(vecs[v].d, 1'b0, '0, lat, bad);
      chk("vec_framing", bad, 0);
      got = decode();
      chk("vec_digest", got, vecs[v].d);
      chk("vec_first_byte", got[255:248], vecs[v].first);
      chk("vec_last_byte", got[7:0], vecs[v].last);
      chk("vec_latency", lat, NCH * FRAME_CLKS);
`ifdef HEX_ASCII_EN
      chk("vec_cr", rxc[64], 8'h0D);
      chk("vec_lf", rxc[65], 8'h0A);
`endif
      @(negedge clk);
      chk("done_one_cycle", done, 0);
    end

    // valid held high, digest changed mid-stream, back-to-back acceptance
    d2 = 256'h0f1e2d3c4b5a69788796a5b4c3d2e1f00123456789abcdeffedcba9876543210;
    xfer(256'hcafef00ddeadbeef0011223344556677_8899aabbccddeeff0102030405060708,
         1'b1, d2, lat, bad);
    chk("hold_framing", bad, 0);
    chk("hold_digest", decode(),
        256'hcafef00ddeadbeef0011223344556677_8899aabbccddeeff0102030405060708);
    chk("hold_ready_on_done", digest_ready, 1);
    chk("hold_busy_on_done", busy, 0);
    @(negedge clk);
    a = cyc;
    digest_valid = 1'b0;
    chk("hold_reaccept_busy", busy, 1);
    chk("hold_reaccept_ready", digest_ready, 0);
    rx_all(a, 1'b0, '0, lat, bad);
    chk("hold_second_framing", bad, 0);
    chk("hold_second_digest", decode(), d2);
    chk("hold_second_latency", lat, NCH * FRAME_CLKS);

    // reset at clock 455 of a transfer
    digest       = '0;
    digest_valid = 1'b1;
    @(negedge clk);
    a = cyc;
    digest_valid = 1'b0;
    while (cyc < a + 454) @(negedge clk);
    chk("pre_reset_tx_low", tx, 0);
    ds    = done_seen;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_tx", tx, 1);
    chk("midreset_busy", busy, 0);
    chk("midreset_ready", digest_ready, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midreset_ready_release", digest_ready, 1);
    xfer(256'hdeadbeef_00000001_11111111_22222222_33333333_44444444_55555555_66666666,
         1'b0, '0, lat, bad);
    chk("post_reset_framing", bad, 0);
    chk("post_reset_digest", decode(),
        256'hdeadbeef_00000001_11111111_22222222_33333333_44444444_55555555_66666666);
    @(negedge clk);
    chk("post_reset_done_count", done_seen, ds + 1);

`ifdef HEX_ASCII_EN
    // hex: 0xA5 then zeros
    xfer({8'hA5, 248'h0}, 1'b0, '0, lat, bad);
    chk("hex_framing", bad, 0);
    chk("hex_c0", rxc[0], 8'h61);
    chk("hex_c1", rxc[1], 8'h35);
    begin
      int zc;
      zc = 0;
      for (int k = 2; k < 64; k++) if (rxc[k] === 8'h30) zc++;
      chk("hex_zero_chars", zc, 62);
    end
    chk("hex_cr", rxc[64], 8'h0D);
    chk("hex_lf", rxc[65], 8'h0A);
    chk("hex_latency", lat, 6600);
`endif

    // loopback of random digests
    for (int r = 0; r < 4; r++) begin
      logic [255:0] rd;
      for (int j = 0; j < 8; j++) rd[32*j +: 32] = $urandom;
      xfer(rd, 1'b0, '0, lat, bad);
      chk("rand_framing", bad, 0);
      chk("rand_digest", decode(), rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #(300_000 * 10);
    $display("FAIL watchdog: got timeout want completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

endmodule
